// File: rtl/d_reg_pipe.sv
// d_reg_pipe: WIDTH-bit, DEPTH-stage stallable register pipeline.
// Each stage carries a data word and a valid bit. The pipeline supports a
// clock enable (stall), a synchronous flush of valid bits, and a registered
// occupancy count equal to the number of valid stages.
module d_reg_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    // Stage 0 is the input end, stage DEPTH-1 drives q.
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next;

    // Occupancy after a shift: one word may enter and one may leave per edge,
    // so the result always stays within 0..DEPTH.
    always_comb begin
        count_next = count_r;
        count_next = count_r + CW'(d_valid) - CW'(valid_r[DEPTH-1]);
    end

    // Data stages: reset loads RESET_VAL; flush leaves data untouched so only
    // the valid bits decide what is meaningful; en shifts one stage forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= RESET_VAL;
            end
        end else if (!flush && en) begin
            data_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                data_r[i] <= data_r[i-1];
            end
        end
    end

    // Valid bits and occupancy count move together so count always matches
    // the popcount of valid_r; reset and flush both empty the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            count_r <= '0;
        end else if (flush) begin
            valid_r <= '0;
            count_r <= '0;
        end else if (en) begin
            valid_r[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
            count_r <= count_next;
        end
    end

    assign q       = data_r[DEPTH-1];
    assign q_valid = valid_r[DEPTH-1];
    assign count   = count_r;

endmodule

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe: directed self-checking bench for d_reg_pipe, exercising a
// DEPTH=4 instance and a DEPTH=1 instance driven from the same inputs.
module tb_d_reg_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       d_valid;

    logic [7:0] q4;
    logic       qv4;
    logic [2:0] count4;
    logic [7:0] q1;
    logic       qv1;
    logic [0:0] count1;

    int n_compared   = 0;
    int n_mismatched = 0;

    d_reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .d(d), .d_valid(d_valid),
        .q(q4), .q_valid(qv4), .count(count4)
    );

    d_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .count(count1)
    );

    // 20 ns clock period
    always #10 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, leaving the inputs idle afterwards.
    task automatic do_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset held two cycles with active-looking inputs must still clear everything.
    task automatic test_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0; d = 8'h3C; d_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_compared++;
            if (q4 !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL reset_q edge %0d: got %h expected a5", k, q4); end
            n_compared++;
            if (qv4 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_qv edge %0d: got %b expected 0", k, qv4); end
            n_compared++;
            if (count4 !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_count edge %0d: got %0d expected 0", k, count4); end
        end
        reset = 1'b0;
    endtask

    // Continuous valid stream: latency 4, count ramps and saturates at 4.
    task automatic test_stream();
        logic [7:0] exp_q;
        logic       exp_qv;
        logic [2:0] exp_cnt;
        en = 1'b1; flush = 1'b0; d_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            d = 8'(k);
            tick();
            exp_q   = (k >= 4) ? 8'(k - 3) : 8'hA5;
            exp_qv  = (k >= 4);
            exp_cnt = (k >= 4) ? 3'd4 : 3'(k);
            n_compared++;
            if (q4 !== exp_q) begin n_mismatched++; $display("[TB] FAIL stream_q edge %0d: got %h expected %h", k, q4, exp_q); end
            n_compared++;
            if (qv4 !== exp_qv) begin n_mismatched++; $display("[TB] FAIL stream_qv edge %0d: got %b expected %b", k, qv4, exp_qv); end
            n_compared++;
            if (count4 !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL stream_count edge %0d: got %0d expected %0d", k, count4, exp_cnt); end
        end
    endtask

    // Stall in the middle of a stream: outputs freeze and latency grows by the stall.
    task automatic test_stall();
        do_reset();
        en = 1'b1; d_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = 8'h10 + 8'(k);
            tick();
        end
        en = 1'b0; d = 8'hEE; d_valid = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            tick();
            n_compared++;
            if (q4 !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL stall_q edge %0d: got %h expected a5", k, q4); end
            n_compared++;
            if (qv4 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_qv edge %0d: got %b expected 0", k, qv4); end
            n_compared++;
            if (count4 !== 3'd3) begin n_mismatched++; $display("[TB] FAIL stall_count edge %0d: got %0d expected 3", k, count4); end
        end
        en = 1'b1; d = 8'h13; d_valid = 1'b1;
        tick();
        n_compared++;
        if (q4 !== 8'h10 || qv4 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_release_q edge 7: got %h/%b expected 10/1", q4, qv4); end
        n_compared++;
        if (count4 !== 3'd4) begin n_mismatched++; $display("[TB] FAIL stall_release_count edge 7: got %0d expected 4", count4); end
        d = 8'h14;
        tick();
        n_compared++;
        if (q4 !== 8'h11 || qv4 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_next_q edge 8: got %h/%b expected 11/1", q4, qv4); end
    endtask

    // Flush a full pipeline (stages hold 14,13,12,11): valids clear, data stays,
    // the FF presented on the flush edge is never delivered as valid.
    task automatic test_flush();
        en = 1'b1; flush = 1'b1; d = 8'hFF; d_valid = 1'b1;
        tick();
        flush = 1'b0;
        n_compared++;
        if (qv4 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_qv: got %b expected 0", qv4); end
        n_compared++;
        if (count4 !== 3'd0) begin n_mismatched++; $display("[TB] FAIL flush_count: got %0d expected 0", count4); end
        n_compared++;
        if (q4 !== 8'h11) begin n_mismatched++; $display("[TB] FAIL flush_q_hold: got %h expected 11", q4); end
        d = 'x; d_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                n_compared++;
                if (q4 !== 8'h12) begin n_mismatched++; $display("[TB] FAIL flush_data_kept: got %h expected 12", q4); end
            end
            n_compared++;
            if (qv4 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_drain_qv edge %0d: got %b expected 0", k, qv4); end
            n_compared++;
            if (count4 !== 3'd0) begin n_mismatched++; $display("[TB] FAIL flush_drain_count edge %0d: got %0d expected 0", k, count4); end
        end
    endtask

    // Alternating valid pattern, then reset mid-stream.
    task automatic test_alternate();
        logic [2:0] exp_cnt [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
        logic       exp_qv;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            d = 8'h1F + 8'(k);
            d_valid = (k % 2 == 1);
            tick();
            n_compared++;
            if (count4 !== exp_cnt[k-1]) begin n_mismatched++; $display("[TB] FAIL alt_count edge %0d: got %0d expected %0d", k, count4, exp_cnt[k-1]); end
            if (k >= 4) begin
                exp_qv = ((k - 3) % 2 == 1);
                n_compared++;
                if (qv4 !== exp_qv) begin n_mismatched++; $display("[TB] FAIL alt_qv edge %0d: got %b expected %b", k, qv4, exp_qv); end
                n_compared++;
                if (q4 !== 8'h1F + 8'(k - 3)) begin n_mismatched++; $display("[TB] FAIL alt_q edge %0d: got %h expected %h", k, q4, 8'h1F + 8'(k - 3)); end
            end
        end
        reset = 1'b1; en = 1'b1; d = 8'h77; d_valid = 1'b1;
        tick();
        reset = 1'b0;
        n_compared++;
        if (q4 !== 8'hA5 || qv4 !== 1'b0 || count4 !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL alt_midreset: got q=%h qv=%b cnt=%0d expected a5/0/0", q4, qv4, count4);
        end
    endtask

    // DEPTH=1 instance: reset behaviour, one-edge latency, count in {0,1}, stall.
    task automatic test_depth1();
        reset = 1'b1; en = 1'b1; flush = 1'b0; d = 8'h3C; d_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_compared++;
            if (q1 !== 8'hA5 || qv1 !== 1'b0 || count1 !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL d1_reset edge %0d: got q=%h qv=%b cnt=%0d expected a5/0/0", k, q1, qv1, count1);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            d = 8'(k); d_valid = 1'b1;
            tick();
            n_compared++;
            if (q1 !== 8'(k) || qv1 !== 1'b1 || count1 !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL d1_stream edge %0d: got q=%h qv=%b cnt=%0d expected %h/1/1", k, q1, qv1, count1, 8'(k));
            end
        end
        en = 1'b0; d = 8'h99; d_valid = 1'b0;
        tick();
        n_compared++;
        if (q1 !== 8'h05 || qv1 !== 1'b1 || count1 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL d1_stall: got q=%h qv=%b cnt=%0d expected 05/1/1", q1, qv1, count1);
        end
        en = 1'b1; d = 8'h66; d_valid = 1'b0;
        tick();
        n_compared++;
        if (q1 !== 8'h66 || qv1 !== 1'b0 || count1 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL d1_invalid: got q=%h qv=%b cnt=%0d expected 66/0/0", q1, qv1, count1);
        end
    endtask

    // Main sequence of directed scenarios.
    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
        #5;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_alternate();
        test_depth1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
